// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the buffered-word-count type used by the read-side stages.
package fifo_pkg;

   localparam int unsigned DATASIZE_DEF = 8;
   localparam int unsigned ADDRSIZE_DEF = 4;

   typedef logic [1:0] level_t;

   localparam level_t LVL_EMPTY = 2'd0;
   localparam level_t LVL_ONE   = 2'd1;
   localparam level_t LVL_FULL  = 2'd2;

endpackage

// File: rtl/read_fwft.sv
// Two-entry first-word-fall-through buffer between the FIFO read port and a valid/ready consumer.
// Define READ_FWFT_LEVEL_EN to expose the buffered word count on the level port.
module read_fwft
   import fifo_pkg::*;
#(
   parameter int unsigned DATASIZE = DATASIZE_DEF,
   parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
   input  logic                rclk,
   input  logic                rst,
   input  logic                empty,
   input  logic [DATASIZE-1:0] rdata,
   output logic                signal_read,
   output logic [DATASIZE-1:0] m_data,
   output logic                m_valid,
`ifdef READ_FWFT_LEVEL_EN
   output level_t              level,
`endif
   input  logic                m_ready
);

   logic [DATASIZE-1:0] head_q, head_d;
   logic [DATASIZE-1:0] tail_q, tail_d;
   level_t              count_q, count_d;
   logic                pop;
   logic                push;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      m_valid     = (count_q != LVL_EMPTY);
      pop         = m_valid & m_ready;
      // Memory has zero latency, so the word fetched by signal_read is captured on the same edge.
      signal_read = ~rst & ~empty & ((count_q != LVL_FULL) | pop);
      push        = signal_read;

      case (count_q)
         LVL_EMPTY: begin
            if (push) begin
               head_d  = rdata;
               count_d = LVL_ONE;
            end
         end
         LVL_ONE: begin
            if (push && pop) begin
               head_d = rdata;
            end else if (push) begin
               tail_d  = rdata;
               count_d = LVL_FULL;
            end else if (pop) begin
               count_d = LVL_EMPTY;
            end
         end
         LVL_FULL: begin
            if (pop) begin
               head_d = tail_q;
               if (push) begin
                  tail_d = rdata;
               end else begin
                  count_d = LVL_ONE;
               end
            end
         end
         default: begin
            count_d = LVL_EMPTY;
         end
      endcase
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= LVL_EMPTY;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign m_data = head_q;

`ifdef READ_FWFT_LEVEL_EN
   assign level = count_q;
`endif

endmodule

// File: tb/tb_read_fwft.sv
// Bench for read_fwft: directed scenarios plus random traffic against a queue model of the buffer.
module tb_read_fwft;

   logic       rclk;
   logic       rst;
   logic       empty;
   logic [7:0] rdata;
   logic       signal_read;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
`ifdef READ_FWFT_LEVEL_EN
   logic [1:0] level;
`endif

   read_fwft #(.DATASIZE(8), .ADDRSIZE(4)) dut (
      .rclk        (rclk),
      .rst         (rst),
      .empty       (empty),
      .rdata       (rdata),
      .signal_read (signal_read),
      .m_data      (m_data),
      .m_valid     (m_valid),
`ifdef READ_FWFT_LEVEL_EN
      .level       (level),
`endif
      .m_ready     (m_ready)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;
   logic [7:0]  model_q[$];
   bit          after_rst = 1'b0;
   int unsigned sr_pulses = 0;
   bit          last_sr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One rclk cycle: drive inputs, check against the model, then advance the model at the edge.
   task automatic step(input bit r, input bit e, input logic [7:0] d, input bit rd);
      bit exp_sr;
      bit do_pop;
      @(negedge rclk);
      rst     = r;
      empty   = e;
      rdata   = d;
      m_ready = rd;
      #1;
      do_pop = (model_q.size() > 0) && rd;
      exp_sr = !r && !e && ((model_q.size() < 2) || do_pop);
      chk("signal_read", {31'd0, signal_read}, {31'd0, exp_sr});
      chk("m_valid", {31'd0, m_valid}, (model_q.size() > 0) ? 32'd1 : 32'd0);
      if (model_q.size() > 0)
         chk("m_data", {24'd0, m_data}, {24'd0, model_q[0]});
      else if (after_rst)
         chk("m_data_rst", {24'd0, m_data}, 32'd0);
`ifdef READ_FWFT_LEVEL_EN
      chk("level", {30'd0, level}, model_q.size());
`endif
      last_sr = signal_read;
      if (signal_read) sr_pulses++;
      @(posedge rclk);
      if (r) begin
         model_q.delete();
         after_rst = 1'b1;
      end else begin
         if (do_pop) void'(model_q.pop_front());
         if (exp_sr) begin
            model_q.push_back(d);
            after_rst = 1'b0;
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      empty   = 1'b0;
      rdata   = 8'h00;
      m_ready = 1'b0;

      // Reset held two cycles with data available: no reads may be issued.
      step(1'b1, 1'b0, 8'hA5, 1'b1);
      step(1'b1, 1'b0, 8'h5A, 1'b1);
      #1;
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);

      // Streaming at full rate.
      step(1'b0, 1'b0, 8'h11, 1'b1);
      #1 chk("stream_first", {24'd0, m_data}, 32'h11);
      step(1'b0, 1'b0, 8'h22, 1'b1);
      #1 chk("stream_second", {24'd0, m_data}, 32'h22);
      step(1'b0, 1'b0, 8'h33, 1'b1);
      #1 chk("stream_third", {24'd0, m_data}, 32'h33);
      step(1'b0, 1'b1, 8'h00, 1'b1);
      #1 chk("stream_drained", {31'd0, m_valid}, 32'd0);

      // Stalled consumer: buffer fills with exactly two reads.
      sr_pulses = 0;
      step(1'b0, 1'b0, 8'h41, 1'b0);
      step(1'b0, 1'b0, 8'h42, 1'b0);
      step(1'b0, 1'b0, 8'h43, 1'b0);
      step(1'b0, 1'b0, 8'h44, 1'b0);
      chk("stall_reads", sr_pulses, 32'd2);
      #1 chk("stall_head", {24'd0, m_data}, 32'h41);

      // Full buffer, consumer resumes: read issued in the same cycle.
      step(1'b0, 1'b0, 8'h45, 1'b1);
      chk("resume_sr", {31'd0, last_sr}, 32'd1);
      #1 chk("resume_head", {24'd0, m_data}, 32'h42);

      // Drain with FIFO empty.
      step(1'b0, 1'b1, 8'h00, 1'b1);
      step(1'b0, 1'b1, 8'h00, 1'b1);
      #1 chk("drain_valid", {31'd0, m_valid}, 32'd0);
      step(1'b0, 1'b1, 8'h00, 1'b1);

      // Reset with two words buffered.
      step(1'b0, 1'b0, 8'h77, 1'b0);
      step(1'b0, 1'b0, 8'h78, 1'b0);
      step(1'b1, 1'b0, 8'h79, 1'b1);
      #1 chk("midrst_valid", {31'd0, m_valid}, 32'd0);
      step(1'b0, 1'b1, 8'h00, 1'b1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(59) == 0),
              ($urandom_range(9) < 3),
              8'($urandom_range(255)),
              ($urandom_range(9) < 6));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/read_fwft.md
READ_FWFT -- requirements
Module: read_fwft

Interface
REQ-001 Parameter: DATASIZE, default 8, width of a FIFO data word.
REQ-002 Parameter: ADDRSIZE, default 4, FIFO address width; carried for package consistency, no effect on datapath.
REQ-003 rclk  input  1  read-domain clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising rclk.
REQ-005 empty  input  1  registered empty flag from the read-pointer stage.
REQ-006 rdata  input  DATASIZE  memory word at the current read address; combinational, valid in the same cycle as the address.
REQ-007 signal_read  output  1  pop request to the read-pointer stage; advances the read address at the next rclk edge.
REQ-008 m_data  output  DATASIZE  head word presented to the consumer.
REQ-009 m_valid  output  1  m_data holds a valid word.
REQ-010 m_ready  input  1  consumer accepts the head word.
REQ-011 level  output  2  buffered word count, 0..2; present only when READ_FWFT_LEVEL_EN is defined.

Function
REQ-012 Block SHALL be a 2-entry first-word-fall-through output buffer between the FIFO read side and a valid/ready consumer.
REQ-013 pop = m_valid & m_ready; a word SHALL transfer on every rclk edge where pop is 1.
REQ-014 signal_read SHALL equal ~rst & ~empty & (count < 2 | pop); m_ready-to-signal_read combinational path permitted.
REQ-015 When signal_read is 1, rdata SHALL be written into the buffer on the same rclk edge (push); zero-cycle memory latency.
REQ-016 Word order at m_data SHALL equal FIFO read order; no loss, no duplication.
REQ-017 m_valid SHALL be 1 iff count > 0; first word SHALL appear on m_valid one cycle after its signal_read.
REQ-018 m_data and m_valid SHALL hold stable while m_valid & ~m_ready.
REQ-019 count 0, push: word becomes head; count -> 1.
REQ-020 count 1, push & pop: new word becomes head; count stays 1.
REQ-021 count 1, push only: new word goes to tail; count -> 2.
REQ-022 count 2, pop & push: tail moves to head, new word to tail; count stays 2.
REQ-023 count 2, no pop: signal_read SHALL be 0 regardless of empty.
REQ-024 pop only: count decrements; tail, if present, becomes head.
REQ-025 Sustained throughput SHALL be one word per cycle when empty = 0 and m_ready = 1.

Reset
REQ-026 While rst = 1: signal_read = 0, and at the edge count -> 0, m_valid -> 0, m_data -> 0, level -> 0.
REQ-027 Reset mid-operation SHALL discard buffered words; no pop is issued during the rst cycle.

Configuration
REQ-028 Macro READ_FWFT_LEVEL_EN defined: level port SHALL exist and equal count.
REQ-029 Macro undefined: level port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package fifo_pkg SHALL hold default DATASIZE/ADDRSIZE constants and the 2-bit level typedef.
REQ-031 Single module, no sub-module; storage is two DATASIZE registers plus a 2-bit count.

Verification
REQ-032 rst held 2 cycles, empty = 0 -> signal_read = 0 throughout; after release m_valid = 0, level = 0.
REQ-033 empty = 0, rdata 0x11, 0x22, 0x33 on successive pops, m_ready = 1 -> m_data 0x11, 0x22, 0x33 on consecutive cycles, first one cycle after the first signal_read.
REQ-034 m_ready = 0, empty = 0 -> exactly two signal_read pulses, then signal_read = 0; level = 2; m_data holds the first word.
REQ-035 count 2, m_ready rises with empty = 0 -> signal_read = 1 in the same cycle; level stays 2; order preserved.
REQ-036 empty = 1 with count 1, m_ready = 1 -> one pop, then m_valid = 0, signal_read = 0.
REQ-037 rst asserted with count 2 -> next cycle m_valid = 0, level = 0; buffered words never appear on m_data.
